// File: rtl/mainfsm.sv
// Multicycle control FSM for the ARM-subset processor: walks each instruction
// through fetch/decode/execute/memory/writeback and emits Moore-style selects.
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic [3:0] State
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       aluop;
    logic [1:0] resultsrc;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
  } ctrl_t;

  state_t state_q;
  ctrl_t  ctrl_q;

  // Only the I bit and the L bit steer the sequence; the rest is for the ALU decoder.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  function automatic state_t next_of(input state_t s, input logic [1:0] op,
                                     input logic ibit, input logic lbit);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:    n = DECODE;
      DECODE: begin
        case (op)
          2'b00:   n = ibit ? EXECUTEI : EXECUTER;
          2'b01:   n = MEMADR;
          2'b10:   n = BRANCH;
          default: n = UNKNOWN;
        endcase
      end
      MEMADR:   n = lbit ? MEMRD : MEMWR;
      MEMRD:    n = MEMWB;
      EXECUTER: n = ALUWB;
      EXECUTEI: n = ALUWB;
      default:  n = FETCH;
    endcase
    return n;
  endfunction

  // Per-state datapath selects; illegal encodings fall through to all-zero.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite   = 1'b1;
        c.nextpc    = 1'b1;
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      MEMADR: begin
        c.alusrcb   = 2'b01;
      end
      MEMRD: begin
        c.adrsrc    = 1'b1;
      end
      MEMWB: begin
        c.regw      = 1'b1;
        c.resultsrc = 2'b01;
      end
      MEMWR: begin
        c.memw      = 1'b1;
        c.adrsrc    = 1'b1;
      end
      EXECUTER: begin
        c.aluop     = 1'b1;
      end
      EXECUTEI: begin
        c.alusrcb   = 2'b01;
        c.aluop     = 1'b1;
      end
      ALUWB: begin
        c.regw      = 1'b1;
      end
      BRANCH: begin
        c.branch    = 1'b1;
        c.alusrcb   = 2'b01;
        c.resultsrc = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Outputs are registered as the decode of the state being entered, so they
  // always match the current state and never see Op/Funct combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= ctrl_of(FETCH);
    end else begin
      state_q <= next_of(state_q, Op, Funct[5], Funct[0]);
      ctrl_q  <= ctrl_of(next_of(state_q, Op, Funct[5], Funct[0]));
    end
  end

  assign IRWrite   = ctrl_q.irwrite;
  assign AdrSrc    = ctrl_q.adrsrc;
  assign ALUSrcA   = ctrl_q.alusrca;
  assign ALUSrcB   = ctrl_q.alusrcb;
  assign ALUOp     = ctrl_q.aluop;
  assign ResultSrc = ctrl_q.resultsrc;
  assign NextPC    = ctrl_q.nextpc;
  assign RegW      = ctrl_q.regw;
  assign MemW      = ctrl_q.memw;
  assign Branch    = ctrl_q.branch;
  assign State     = STATE_W'(state_q);

endmodule

// File: tb/tb_mainfsm.sv
// Self-checking bench for mainfsm: directed instruction table, reset corners,
// then random instruction streams against an instruction-level model.
module tb_mainfsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] State;

  int n_checks = 0;
  int n_fail   = 0;

  mainfsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    int         len;
    int         seq[6];
  } vec_t;

  vec_t vecs[6];

  // Expected outputs packed as {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ALUOp,ResultSrc,NextPC,RegW,MemW,Branch}.
  function automatic logic [11:0] pack_out(input logic irw, input logic adr, input logic a,
                                           input logic [1:0] b, input logic aop,
                                           input logic [1:0] res, input logic npc,
                                           input logic rw, input logic mw, input logic br);
    return {irw, adr, a, b, aop, res, npc, rw, mw, br};
  endfunction

  function automatic logic [11:0] exp_out(input int st);
    case (st)
      0:  return pack_out(1, 0, 1, 2'b10, 0, 2'b10, 1, 0, 0, 0);
      1:  return pack_out(0, 0, 1, 2'b10, 0, 2'b10, 0, 0, 0, 0);
      2:  return pack_out(0, 0, 0, 2'b01, 0, 2'b00, 0, 0, 0, 0);
      3:  return pack_out(0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
      4:  return pack_out(0, 0, 0, 2'b00, 0, 2'b01, 0, 1, 0, 0);
      5:  return pack_out(0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 1, 0);
      6:  return pack_out(0, 0, 0, 2'b00, 1, 2'b00, 0, 0, 0, 0);
      7:  return pack_out(0, 0, 0, 2'b01, 1, 2'b00, 0, 0, 0, 0);
      8:  return pack_out(0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0, 0);
      9:  return pack_out(0, 0, 0, 2'b01, 0, 2'b10, 0, 0, 0, 1);
      default: return 12'h000;
    endcase
  endfunction

  // Instruction-level model: the state walk each instruction class must take.
  function automatic int model_seq(input logic [1:0] op, input logic [5:0] f, output int s[6]);
    s = '{default: 0};
    s[1] = 1;
    case (op)
      2'b00: begin s[2] = f[5] ? 7 : 6; s[3] = 8; return 4; end
      2'b01: begin
        s[2] = 2;
        if (f[0]) begin s[3] = 3; s[4] = 4; return 5; end
        s[3] = 5; return 4;
      end
      2'b10: begin s[2] = 9; return 3; end
      default: begin s[2] = 10; return 3; end
    endcase
  endfunction

  function automatic logic [11:0] dut_out();
    return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, NextPC, RegW, MemW, Branch};
  endfunction

  task automatic check_state(input string name, input int exp_st);
    n_checks++;
    if (int'(State) != exp_st) begin
      n_fail++;
      $display("FAIL %s state: got %0d expected %0d", name, State, exp_st);
    end
    n_checks++;
    if (dut_out() !== exp_out(exp_st)) begin
      n_fail++;
      $display("FAIL %s outputs in state %0d: got %b expected %b", name, exp_st,
               dut_out(), exp_out(exp_st));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left 1 time unit after a rising edge with the FSM in FETCH.
  task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] f,
                           input int len, input int seq[6]);
    Op = op;
    Funct = f;
    for (int k = 0; k < len; k++) begin
      check_state($sformatf("%s step%0d", name, k), seq[k]);
      tick();
    end
    check_state($sformatf("%s return", name), 0);
  endtask

  // Reset held for two edges after `steps` cycles into an instruction.
  task automatic reset_mid(input string name, input logic [1:0] op, input logic [5:0] f,
                           input int steps, input int exp_here);
    Op = op;
    Funct = f;
    for (int k = 0; k < steps; k++) tick();
    if (exp_here >= 0) check_state($sformatf("%s pre-reset", name), exp_here);
    reset = 1'b1;
    tick();
    check_state($sformatf("%s hold1", name), 0);
    tick();
    check_state($sformatf("%s hold2", name), 0);
    reset = 1'b0;
    check_state($sformatf("%s released", name), 0);
  endtask

  initial begin
    int s[6];
    int len;
    logic [1:0] rop;
    logic [5:0] rf;

    vecs[0].op = 2'b00; vecs[0].funct = 6'b000000; vecs[0].len = 4; vecs[0].seq = '{0, 1, 6, 8, 0, 0};
    vecs[1].op = 2'b00; vecs[1].funct = 6'b101000; vecs[1].len = 4; vecs[1].seq = '{0, 1, 7, 8, 0, 0};
    vecs[2].op = 2'b01; vecs[2].funct = 6'b011001; vecs[2].len = 5; vecs[2].seq = '{0, 1, 2, 3, 4, 0};
    vecs[3].op = 2'b01; vecs[3].funct = 6'b011000; vecs[3].len = 4; vecs[3].seq = '{0, 1, 2, 5, 0, 0};
    vecs[4].op = 2'b10; vecs[4].funct = 6'b000000; vecs[4].len = 3; vecs[4].seq = '{0, 1, 9, 0, 0, 0};
    vecs[5].op = 2'b11; vecs[5].funct = 6'b111111; vecs[5].len = 3; vecs[5].seq = '{0, 1, 10, 0, 0, 0};

    reset = 1'b1;
    Op    = 2'b00;
    Funct = 6'b000000;
    tick();
    tick();
    check_state("power-on reset", 0);
    reset = 1'b0;
    check_state("after release", 0);

    for (int i = 0; i < 6; i++)
      run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].funct, vecs[i].len, vecs[i].seq);

    // Reset mid-load in MEMRD, mid-store in MEMADR, and inside EXECUTEI.
    reset_mid("rst_memrd", 2'b01, 6'b011001, 3, 3);
    run_instr("after_rst_memrd", vecs[0].op, vecs[0].funct, vecs[0].len, vecs[0].seq);
    reset_mid("rst_memadr", 2'b01, 6'b011000, 2, 2);
    reset_mid("rst_execi", 2'b00, 6'b100000, 2, 7);
    reset_mid("rst_fetch", 2'b10, 6'b000000, 0, 0);
    run_instr("after_rst_fetch", vecs[2].op, vecs[2].funct, vecs[2].len, vecs[2].seq);

    for (int i = 0; i < 300; i++) begin
      rop = 2'($urandom_range(0, 3));
      rf  = 6'($urandom);
      len = model_seq(rop, rf, s);
      if ($urandom_range(0, 9) == 0)
        reset_mid($sformatf("rnd%0d rst", i), rop, rf, $urandom_range(0, len - 1), -1);
      else
        run_instr($sformatf("rnd%0d", i), rop, rf, len, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
